mult_div_unit: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 50 +++++
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit_sign_fix.sv | 14 +
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control constants: ALU control codes, instruction funct/opcode
// fields, the mult_div_unit state encoding and the datapath width.
package alu_ctrl_pkg;

    localparam int WIDTH = 32;

    // 4-bit ALU control codes
    localparam logic [3:0] OPAND  = 4'b0000;
    localparam logic [3:0] OPOR   = 4'b0001;
    localparam logic [3:0] OPADD  = 4'b0010;
    localparam logic [3:0] OPXOR  = 4'b0011;
    localparam logic [3:0] OPSUB  = 4'b0110;
    localparam logic [3:0] OPSLT  = 4'b0111;
    localparam logic [3:0] OPMFHI = 4'b1011;
    localparam logic [3:0] OPMFLO = 4'b1100;
    localparam logic [3:0] OPMULT = 4'b1101;
    localparam logic [3:0] OPDIV  = 4'b1110;

    // R-type funct field values
    localparam logic [5:0] FUNMFHI = 6'h10;
    localparam logic [5:0] FUNMFLO = 6'h12;
    localparam logic [5:0] FUNMULT = 6'h18;
    localparam logic [5:0] FUNDIV  = 6'h1A;
    localparam logic [5:0] FUNADD  = 6'h20;
    localparam logic [5:0] FUNSUB  = 6'h22;
    localparam logic [5:0] FUNAND  = 6'h24;
    localparam logic [5:0] FUNOR   = 6'h25;
    localparam logic [5:0] FUNXOR  = 6'h26;
    localparam logic [5:0] FUNSLT  = 6'h2A;

    // Primary opcode field values
    localparam logic [5:0] OPCRTYPE = 6'h00;
    localparam logic [5:0] OPCBEQ   = 6'h04;
    localparam logic [5:0] OPCADDI  = 6'h08;
    localparam logic [5:0] OPCLW    = 6'h23;
    localparam logic [5:0] OPCSW    = 6'h2B;

    // mult_div_unit state encoding
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_MUL  = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;
    localparam logic [1:0] MD_FIX  = 2'd3;

    // True for every code that is owned by the multiply/divide unit
    function automatic logic is_md_code(input logic [3:0] code);
        return (code == OPMULT) || (code == OPDIV) ||
               (code == OPMFHI) || (code == OPMFLO);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage bus between the pipeline and mult_div_unit.
interface mult_div_unit_if #(parameter int WIDTH = alu_ctrl_pkg::WIDTH);

    logic             iValid;
    logic [3:0]       iControlSignal;
    logic [WIDTH-1:0] iOperandA;
    logic [WIDTH-1:0] iOperandB;
    logic [WIDTH-1:0] oResult;
    logic             oBusy;
    logic             oStall;
    logic             oDone;
    logic             oDivByZero;
    logic [WIDTH-1:0] oHi;
    logic [WIDTH-1:0] oLo;

    modport master (
        output iValid, iControlSignal, iOperandA, iOperandB,
        input  oResult, oBusy, oStall, oDone, oDivByZero, oHi, oLo
    );

    modport slave (
        input  iValid, iControlSignal, iOperandA, iOperandB,
        output oResult, oBusy, oStall, oDone, oDivByZero, oHi, oLo
    );

endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negation; with iNegate tied to the value's
// MSB it yields the absolute value.
module mult_div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] iValue,
    input  logic         iNegate,
    output logic [W-1:0] oValue
);

    // Negate when requested, pass through otherwise
    always_comb oValue = iNegate ? (~iValue + W'(1)) : iValue;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 shift-add) and restoring divide with
// architectural HI/LO registers. Optional macro MULTDIV_EARLY_OUT_EN lets a
// multiply finish as soon as the remaining multiplier bits are all zero.
module mult_div_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = alu_ctrl_pkg::WIDTH,
    parameter int CNT_W = 5
) (
    input logic             iClk,
    input logic             iReset_n,
    mult_div_unit_if.slave  bus
);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;       // MUL: product; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand_q, mcand_d;   // |A|, shifted left during MUL
    logic [WIDTH-1:0]   b_q, b_d;           // |B|, shifted right during MUL
    logic               sign_res_q, sign_res_d;
    logic               sign_a_q, sign_a_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix, orig_a;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic               last_step;

    mult_div_sign_fix #(.W(WIDTH)) u_abs_a (
        .iValue(bus.iOperandA), .iNegate(bus.iOperandA[WIDTH-1]), .oValue(abs_a));
    mult_div_sign_fix #(.W(WIDTH)) u_abs_b (
        .iValue(bus.iOperandB), .iNegate(bus.iOperandB[WIDTH-1]), .oValue(abs_b));
    mult_div_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .iValue(acc_q), .iNegate(sign_res_q), .oValue(prod_fix));
    mult_div_sign_fix #(.W(WIDTH)) u_fix_quo (
        .iValue(acc_q[WIDTH-1:0]), .iNegate(sign_res_q), .oValue(quo_fix));
    mult_div_sign_fix #(.W(WIDTH)) u_fix_rem (
        .iValue(acc_q[2*WIDTH-1:WIDTH]), .iNegate(sign_a_q), .oValue(rem_fix));
    // Re-signing the latched |A| recovers the original dividend (0x80000000 included)
    mult_div_sign_fix #(.W(WIDTH)) u_fix_a (
        .iValue(mcand_q[WIDTH-1:0]), .iNegate(sign_a_q), .oValue(orig_a));

    // Next-state, datapath step and HI/LO write selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        b_d        = b_q;
        sign_res_d = sign_res_q;
        sign_a_d   = sign_a_q;
        is_div_d   = is_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        last_step  = (cnt_q == CNT_W'(WIDTH - 1));
        rem_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff   = rem_shift - {1'b0, b_q};

        case (state_q)
            MD_IDLE: begin
                if (bus.iValid && (bus.iControlSignal == OPMULT ||
                                   bus.iControlSignal == OPDIV)) begin
                    is_div_d   = (bus.iControlSignal == OPDIV);
                    sign_a_d   = bus.iOperandA[WIDTH-1];
                    sign_res_d = bus.iOperandA[WIDTH-1] ^ bus.iOperandB[WIDTH-1];
                    mcand_d    = {{WIDTH{1'b0}}, abs_a};
                    b_d        = abs_b;
                    acc_d      = (bus.iControlSignal == OPDIV) ?
                                 {{WIDTH{1'b0}}, abs_a} : '0;
                    cnt_d      = '0;
                    state_d    = (bus.iControlSignal == OPDIV) ? MD_DIV : MD_MUL;
                end
            end
            MD_MUL: begin
                if (b_q[0]) acc_d = acc_q + mcand_q;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef MULTDIV_EARLY_OUT_EN
                if (b_q[WIDTH-1:1] == '0) last_step = 1'b1;
`endif
                if (last_step) state_d = MD_FIX;
            end
            MD_DIV: begin
                if (rem_diff[WIDTH])
                    acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                else
                    acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) state_d = MD_FIX;
            end
            default: begin
                if (is_div_q && b_q == '0) begin
                    hi_d  = orig_a;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears HI/LO
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            b_q        <= '0;
            sign_res_q <= 1'b0;
            sign_a_q   <= 1'b0;
            is_div_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            b_q        <= b_d;
            sign_res_q <= sign_res_d;
            sign_a_q   <= sign_a_d;
            is_div_q   <= is_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    // HI/LO read-out for the move-from codes
    always_comb begin
        case (bus.iControlSignal)
            OPMFHI:  bus.oResult = hi_q;
            OPMFLO:  bus.oResult = lo_q;
            default: bus.oResult = '0;
        endcase
    end

    assign bus.oBusy      = (state_q != MD_IDLE);
    assign bus.oStall     = bus.iValid && is_md_code(bus.iControlSignal) &&
                            (state_q != MD_IDLE);
    assign bus.oDone      = done_q;
    assign bus.oDivByZero = dbz_q;
    assign bus.oHi        = hi_q;
    assign bus.oLo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, stall and
// reset scenarios, and randomized MULT/DIV against an arithmetic model.
module tb_mult_div_unit;
    import alu_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    mult_div_unit_if #(.WIDTH(32)) bus();

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .iClk     (clk),
        .iReset_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: signed arithmetic on plain integers
    function automatic void model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz, output int lat);
        int sa, sb, q, r;
        longint p;
        logic [31:0] ub;
        sa  = a;
        sb  = b;
        dz  = 1'b0;
        lat = 33;
        if (code == OPMULT) begin
            p = longint'(sa) * longint'(sb);
            {hi, lo} = p;
`ifdef MULTDIV_EARLY_OUT_EN
            ub  = b[31] ? (~b + 32'd1) : b;
            lat = 2;
            for (int i = 0; i < 32; i++) if (ub[i]) lat = i + 2;
`else
            ub = b;
`endif
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFFFFFF;
            dz = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            hi = 32'd0;
            lo = 32'h80000000;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r;
            lo = q;
        end
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'h80000000;
            2: v = 32'hFFFFFFFF;
            3: v = 32'd1;
            4: v = $urandom_range(0, 255);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Present an op for one edge (E0), then scramble the operand inputs
    task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.iValid         = 1'b1;
        bus.iControlSignal = code;
        bus.iOperandA      = a;
        bus.iOperandB      = b;
        @(posedge clk);
        #1;
        bus.iValid         = 1'b0;
        bus.iControlSignal = 4'($urandom_range(0, 15));
        bus.iOperandA      = $urandom;
        bus.iOperandB      = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.oDone) break;
        end
    endtask

    task automatic check_result(input string tag, input int n, input int lat,
                                input logic [31:0] eh, input logic [31:0] el, input logic edz);
        check_eq({tag, ".latency"}, 64'(n), 64'(lat));
        check_eq({tag, ".hi"}, bus.oHi, eh);
        check_eq({tag, ".lo"}, bus.oLo, el);
        check_eq({tag, ".dbz"}, bus.oDivByZero, edz);
        check_eq({tag, ".busy_end"}, bus.oBusy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] code,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        edz;
        int          lat, n;
        model(code, a, b, eh, el, edz, lat);
        issue(code, a, b);
        check_eq({tag, ".busy"}, bus.oBusy, 1'b1);
        wait_done(n);
        check_result(tag, n, lat, eh, el, edz);
        @(posedge clk);
        #1;
        check_eq({tag, ".pulse"}, bus.oDone, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] eh, el, xa, xb;
        logic        edz;
        int          lat, n, dones;
        logic [3:0]  code;

        bus.iValid         = 1'b0;
        bus.iControlSignal = OPADD;
        bus.iOperandA      = '0;
        bus.iOperandB      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.busy", bus.oBusy, 1'b0);
        check_eq("rst.done", bus.oDone, 1'b0);
        check_eq("rst.dbz", bus.oDivByZero, 1'b0);
        check_eq("rst.hi", bus.oHi, 32'd0);
        check_eq("rst.lo", bus.oLo, 32'd0);
        rst_n = 1'b1;

        // Directed corner cases
        run_op("mul7xm3", OPMULT, 32'd7, 32'hFFFFFFFD);
        @(negedge clk);
        bus.iValid = 1'b1;
        bus.iControlSignal = OPMFHI;
        #1;
        check_eq("idle_mfhi.res", bus.oResult, 32'hFFFFFFFF);
        check_eq("idle_mfhi.stall", bus.oStall, 1'b0);
        bus.iControlSignal = OPMFLO;
        #1;
        check_eq("idle_mflo.res", bus.oResult, 32'hFFFFFFEB);
        check_eq("idle_mflo.stall", bus.oStall, 1'b0);
        bus.iValid = 1'b0;
        bus.iControlSignal = OPADD;
        #1;
        check_eq("idle_other.res", bus.oResult, 32'd0);

        run_op("divm7d2", OPDIV, 32'hFFFFFFF9, 32'd2);
        run_op("divmin", OPDIV, 32'h80000000, 32'hFFFFFFFF);
        run_op("div5d0", OPDIV, 32'd5, 32'd0);
        run_op("divm9d0", OPDIV, 32'hFFFFFFF7, 32'd0);
        run_op("mul5x3", OPMULT, 32'd5, 32'd3);
        run_op("mulx0", OPMULT, 32'h1234, 32'd0);
        run_op("mulminxmin", OPMULT, 32'h80000000, 32'h80000000);

        // MFHI arriving mid-multiply is stalled until HI is written
        model(OPMULT, 32'h12345678, 32'hFEDCBA98, eh, el, edz, lat);
        issue(OPMULT, 32'h12345678, 32'hFEDCBA98);
        repeat (9) @(posedge clk);
        #1;
        bus.iValid = 1'b1;
        bus.iControlSignal = OPMFHI;
        #1;
        check_eq("mfhi_busy.stall", bus.oStall, 1'b1);
        wait_done(n);
        check_eq("mfhi_busy.latency", 64'(n), 64'(lat - 9));
        check_eq("mfhi_busy.stall_end", bus.oStall, 1'b0);
        check_eq("mfhi_busy.res", bus.oResult, eh);
        bus.iValid = 1'b0;

        // Non-MD code never stalls; a MULT arriving while busy is held then accepted
        xa = $urandom;
        xb = $urandom;
        model(OPDIV, 32'd1000, 32'hFFFFFFF9, eh, el, edz, lat);
        issue(OPDIV, 32'd1000, 32'hFFFFFFF9);
        bus.iValid = 1'b1;
        bus.iControlSignal = OPADD;
        #1;
        check_eq("add_busy.stall", bus.oStall, 1'b0);
        check_eq("add_busy.res", bus.oResult, 32'd0);
        bus.iControlSignal = OPMULT;
        bus.iOperandA = xa;
        bus.iOperandB = xb;
        #1;
        check_eq("held_mult.stall", bus.oStall, 1'b1);
        wait_done(n);
        check_result("held_div", n, lat, eh, el, edz);
        check_eq("held_mult.stall_idle", bus.oStall, 1'b0);
        model(OPMULT, xa, xb, eh, el, edz, lat);
        @(posedge clk);
        #1;
        check_eq("held_mult.accepted", bus.oBusy, 1'b1);
        bus.iValid = 1'b0;
        bus.iOperandA = $urandom;
        bus.iOperandB = $urandom;
        wait_done(n);
        check_result("held_mult", n, lat, eh, el, edz);

        // Reset during a divide aborts it and clears HI/LO
        issue(OPDIV, 32'd1000, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_mid.busy", bus.oBusy, 1'b0);
        check_eq("rst_mid.hi", bus.oHi, 32'd0);
        check_eq("rst_mid.lo", bus.oLo, 32'd0);
        check_eq("rst_mid.done", bus.oDone, 1'b0);
        rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.oDone) dones++;
        end
        check_eq("rst_mid.no_done", 64'(dones), 64'd0);
        run_op("mul3x4", OPMULT, 32'd3, 32'd4);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            code = ($urandom_range(0, 1) == 0) ? OPMULT : OPDIV;
            run_op((code == OPMULT) ? "rnd_mul" : "rnd_div", code, pick(), pick());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
